// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller: FSM encoding,
// register indices and active-id width.
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_PEND   = 3'd2;
  localparam logic [2:0] REG_ACTIVE = 3'd3;

  localparam int ID_W = 5;

endpackage

// File: rtl/intc_edge_det.sv
// Rising-edge detector for the IRQ lines; with INTC_SYNC_EN defined each line
// first passes through a two-flop synchronizer.
module intc_edge_det #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] samp;
  logic [W-1:0] hist;

`ifdef INTC_SYNC_EN
  logic [W-1:0] meta;
  logic [W-1:0] sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  assign samp = sync;
`else
  assign samp = din;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= '0;
    else       hist <= samp;
  end

  assign rise = samp & ~hist;

endmodule

// File: rtl/intc.sv
// Prioritized interrupt controller on the word-addressed peripheral bus.
// Optional input synchronizer selected by INTC_SYNC_EN (see intc_edge_det).
module intc
  import intc_pkg::*;
#(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] irq_in,
  input  logic            ack,
  output logic            irq_out,
  output logic [ID_W-1:0] active_id
);

  state_t            state;
  logic              ctrl_en;
  logic [NSRC-1:0]   mask;
  logic [NSRC-1:0]   pending;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   masked;
  logic [NSRC-1:0]   w1c_clr;
  logic [NSRC-1:0]   ack_clr;
  logic [ID_W-1:0]   winner;
  logic [2:0]        idx;
  logic              req;
  logic              take;
  logic              eoi_ok;
  logic              unused_bits;

  assign idx         = Addr[4:2];
  assign unused_bits = ^{Addr[31:5], Din};

  intc_edge_det #(.W(NSRC)) u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (irq_in),
    .rise  (rise)
  );

  assign masked = pending & mask;
  assign req    = ctrl_en & (|masked);
  assign take   = (state == ST_ASSERT) && req && ack;
  assign eoi_ok = (state == ST_SERVICE) && WE && (idx == REG_ACTIVE)
                  && (Din[ID_W-1:0] == active_id);

  // Lowest set index wins, so scan downward and let the last hit stand.
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    w1c_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i] = take && (winner == ID_W'(i));
    end
    if (WE && idx == REG_PEND) w1c_clr = Din[NSRC-1:0];
  end

  // New edges are OR-ed in last so they win over both clear sources.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en <= 1'b0;
      mask    <= '0;
      pending <= '0;
    end else begin
      if (WE && idx == REG_CTRL) ctrl_en <= Din[0];
      if (WE && idx == REG_MASK) mask    <= Din[NSRC-1:0];
      pending <= (pending & ~w1c_clr & ~ack_clr) | rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      irq_out   <= 1'b0;
      active_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          irq_out <= req;
          if (req) state <= ST_ASSERT;
        end
        ST_ASSERT: begin
          if (!req) begin
            state   <= ST_IDLE;
            irq_out <= 1'b0;
          end else if (ack) begin
            state     <= ST_SERVICE;
            irq_out   <= 1'b0;
            active_id <= winner + ID_W'(1);
          end
        end
        ST_SERVICE: begin
          irq_out <= 1'b0;
          if (eoi_ok) begin
            state     <= ST_IDLE;
            active_id <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq_out <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (idx)
      REG_CTRL:   Dout = {31'd0, ctrl_en};
      REG_MASK:   Dout = 32'(mask);
      REG_PEND:   Dout = 32'(pending);
      REG_ACTIVE: Dout = 32'(active_id);
      default:    Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: register/edge-capture vector table followed by
// hand-written handshake sequences. Targets the default (unsynchronized) build.
module tb_intc;

  localparam int NSRC = 6;

  logic            clk;
  logic            reset;
  logic [31:2]     Addr;
  logic            WE;
  logic [31:0]     Din;
  logic [31:0]     Dout;
  logic [NSRC-1:0] irq_in;
  logic            ack;
  logic            irq_out;
  logic [4:0]      active_id;

  int nvec;
  int nerr;

  intc #(.NSRC(NSRC)) dut (
    .clk       (clk),
    .reset     (reset),
    .Addr      (Addr),
    .WE        (WE),
    .Din       (Din),
    .Dout      (Dout),
    .irq_in    (irq_in),
    .ack       (ack),
    .irq_out   (irq_out),
    .active_id (active_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      idx;
    logic [31:0]     wdata;
    logic [NSRC-1:0] irq;
    logic [2:0]      rd_idx;
    logic [31:0]     exp_rd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    Addr = {27'h123_4567, idx};
    Din  = d;
    WE   = 1'b1;
    step(1);
    WE   = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [2:0] idx, input logic [31:0] exp);
    Addr = {27'h0AB_CDEF, idx};
    #1;
    chk(name, Dout, exp);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    WE     = 1'b0;
    ack    = 1'b0;
    irq_in = '0;
    Din    = '0;
    Addr   = '0;
    reset  = 1'b1;
    step(1);
    reset  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    nvec = 0;
    nerr = 0;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 6'h00, 3'd0, 32'h0000_0001};
    vecs[1]  = '{3'd1, 32'hFFFF_FFC0, 6'h00, 3'd1, 32'h0000_0000};
    vecs[2]  = '{3'd4, 32'hFFFF_FFFF, 6'h00, 3'd4, 32'h0000_0000};
    vecs[3]  = '{3'd0, 32'h0000_0000, 6'h05, 3'd2, 32'h0000_0005};
    vecs[4]  = '{3'd7, 32'h0000_00FF, 6'h05, 3'd2, 32'h0000_0005};
    vecs[5]  = '{3'd2, 32'h0000_0001, 6'h05, 3'd2, 32'h0000_0004};
    vecs[6]  = '{3'd2, 32'h0000_0004, 6'h24, 3'd2, 32'h0000_0020};
    vecs[7]  = '{3'd2, 32'h0000_0020, 6'h25, 3'd2, 32'h0000_0001};
    vecs[8]  = '{3'd2, 32'h0000_003F, 6'h00, 3'd2, 32'h0000_0000};
    vecs[9]  = '{3'd1, 32'h0000_002A, 6'h00, 3'd1, 32'h0000_002A};
    vecs[10] = '{3'd3, 32'h0000_0000, 6'h00, 3'd3, 32'h0000_0000};

    do_reset();
    chk("reset_irq_out", 32'(irq_out), 32'h0);
    chk("reset_active_id", 32'(active_id), 32'h0);
    chk_rd("reset_pend", 3'd2, 32'h0);

    for (int i = 0; i < 11; i++) begin
      irq_in = vecs[i].irq;
      wr(vecs[i].idx, vecs[i].wdata);
      chk_rd($sformatf("vec%0d_rd", i), vecs[i].rd_idx, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq_out", i), 32'(irq_out), 32'h0);
    end

    // basic assert / ack / EOI
    do_reset();
    wr(3'd0, 32'h1);
    wr(3'd1, 32'h3F);
    irq_in = 6'h04;
    step(1);
    irq_in = 6'h00;
    chk_rd("a_pend_latched", 3'd2, 32'h04);
    chk("a_irq_not_yet", 32'(irq_out), 32'h0);
    step(1);
    chk("a_irq_asserted", 32'(irq_out), 32'h1);
    pulse_ack();
    chk("a_active_id", 32'(active_id), 32'd3);
    chk("a_irq_dropped", 32'(irq_out), 32'h0);
    chk_rd("a_pend_cleared", 3'd2, 32'h0);
    chk_rd("a_active_reg", 3'd3, 32'd3);
    wr(3'd3, 32'd3);
    chk("a_eoi_active", 32'(active_id), 32'd0);
    step(1);
    chk("a_idle_irq", 32'(irq_out), 32'h0);

    // two simultaneous edges, priority and re-assert after EOI
    irq_in = 6'h12;
    step(1);
    irq_in = 6'h00;
    step(1);
    chk("b_irq_asserted", 32'(irq_out), 32'h1);
    pulse_ack();
    chk("b_active_2", 32'(active_id), 32'd2);
    chk_rd("b_pend_left", 3'd2, 32'h10);
    wr(3'd3, 32'd2);
    chk("b_irq_low_after_eoi", 32'(irq_out), 32'h0);
    step(1);
    chk("b_irq_reassert", 32'(irq_out), 32'h1);
    pulse_ack();
    chk("b_active_5", 32'(active_id), 32'd5);
    chk_rd("b_pend_empty", 3'd2, 32'h0);
    wr(3'd3, 32'd5);

    // masked pending becomes visible after unmasking
    wr(3'd1, 32'h01);
    irq_in = 6'h08;
    step(1);
    irq_in = 6'h00;
    step(1);
    chk_rd("c_pend_masked", 3'd2, 32'h08);
    chk("c_irq_masked", 32'(irq_out), 32'h0);
    wr(3'd1, 32'h08);
    step(1);
    chk("c_irq_unmasked", 32'(irq_out), 32'h1);
    wr(3'd2, 32'h08);
    step(1);
    chk("c_irq_withdrawn", 32'(irq_out), 32'h0);

    // W1C in ASSERT, then W1C racing a new edge on the same bit
    wr(3'd1, 32'h3F);
    irq_in = 6'h01;
    step(1);
    irq_in = 6'h00;
    step(1);
    chk("d_irq_asserted", 32'(irq_out), 32'h1);
    wr(3'd2, 32'h01);
    step(1);
    chk("d_irq_withdrawn", 32'(irq_out), 32'h0);
    chk_rd("d_pend_cleared", 3'd2, 32'h0);
    irq_in = 6'h01;
    step(1);
    irq_in = 6'h00;
    step(1);
    chk("d_irq_again", 32'(irq_out), 32'h1);
    irq_in = 6'h01;
    wr(3'd2, 32'h01);
    irq_in = 6'h00;
    chk_rd("d_edge_beats_w1c", 3'd2, 32'h01);
    step(1);
    chk("d_irq_held", 32'(irq_out), 32'h1);
    wr(3'd2, 32'h01);
    step(2);

    // ack in IDLE ignored; SERVICE ignores ack, CTRL clear, mismatched EOI
    pulse_ack();
    chk("e_ack_idle_ignored", 32'(active_id), 32'd0);
    irq_in = 6'h01;
    step(2);
    chk("e_irq_asserted", 32'(irq_out), 32'h1);
    pulse_ack();
    chk("e_active_1", 32'(active_id), 32'd1);
    pulse_ack();
    chk("e_ack_service_ignored", 32'(active_id), 32'd1);
    wr(3'd0, 32'h0);
    chk("e_ctrl_clear_no_abort", 32'(active_id), 32'd1);
    wr(3'd3, 32'd2);
    step(1);
    chk("e_bad_eoi_ignored", 32'(active_id), 32'd1);
    chk("e_service_irq_low", 32'(irq_out), 32'h0);
    wr(3'd3, 32'd1);
    chk("e_good_eoi", 32'(active_id), 32'd0);
    wr(3'd0, 32'h1);
    step(2);
    chk("e_level_no_repend_irq", 32'(irq_out), 32'h0);
    chk_rd("e_level_no_repend", 3'd2, 32'h0);
    irq_in = 6'h00;

    // asynchronous reset in the middle of service
    irq_in = 6'h04;
    step(1);
    irq_in = 6'h00;
    step(1);
    pulse_ack();
    chk("g_active_3", 32'(active_id), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("g_rst_irq_out", 32'(irq_out), 32'h0);
    chk("g_rst_active_id", 32'(active_id), 32'd0);
    chk_rd("g_rst_ctrl", 3'd0, 32'h0);
    chk_rd("g_rst_mask", 3'd1, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
